// File: rtl/bsg_global_buffer_sched_pkg.sv
// Shared types for the global-buffer row scheduler and its tag queue.
package bsg_global_buffer_sched_pkg;

  typedef enum logic [1:0] {
    SCHED_RUN   = 2'd0,
    SCHED_DRAIN = 2'd1,
    SCHED_DONE  = 2'd2
  } sched_state_e;

  // Output-stage beat at fixed reference widths; the scheduler declares a
  // same-shaped struct at its own parameterized widths.
  localparam int SCHED_REF_ADDR_W = 32;
  localparam int SCHED_REF_DATA_W = 32;

  typedef struct packed {
    logic                        w;
    logic [SCHED_REF_ADDR_W-1:0] addr;
    logic [SCHED_REF_DATA_W-1:0] data;
  } sched_out_s;

endpackage

// File: rtl/bsg_global_buffer_tag_fifo.sv
// In-order tag queue: holds the requester index of every outstanding read.
module bsg_global_buffer_tag_fifo
  import bsg_global_buffer_sched_pkg::*;
#(
  parameter int depth_p = 8,
  parameter int width_p = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  input  logic               yumi_i,
  output logic [width_p-1:0] data_o,
  output logic               empty_o
);
  localparam int PW = (depth_p > 1) ? $clog2(depth_p) : 1;
  localparam int CW = $clog2(depth_p + 1);

  logic [width_p-1:0] r_mem [depth_p];
  logic [PW-1:0]      r_wptr, r_rptr;
  logic [CW-1:0]      r_cnt;
  logic               w_push, w_pop;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(depth_p - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty_o = (r_cnt == '0);
  assign w_pop   = yumi_i & ~empty_o;
  assign w_push  = v_i & ((r_cnt != CW'(depth_p)) | w_pop);
  assign data_o  = r_mem[r_rptr];

  always_ff @(posedge clk_i)
    if (w_push) r_mem[r_wptr] <= data_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= f_inc(r_wptr);
      if (w_pop)  r_rptr <= f_inc(r_rptr);
      if (w_push & ~w_pop)      r_cnt <= r_cnt + CW'(1);
      else if (~w_push & w_pop) r_cnt <= r_cnt - CW'(1);
    end
  end

endmodule

// File: rtl/bsg_global_buffer_row_sched.sv
// Per-row scheduler: round-robin injection onto one ring row with read-credit metering.
// Optional perf counters are built when BSG_GLOBAL_BUFFER_SCHED_PERF_EN is defined.
module bsg_global_buffer_row_sched
  import bsg_global_buffer_sched_pkg::*;
#(
  parameter int num_req_p    = 4,
  parameter int addr_width_p = -1,
  parameter int data_width_p = -1,
  parameter int max_out_p    = 8
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic [num_req_p-1:0]                     req_v_i,
  input  logic [num_req_p-1:0]                     req_w_i,
  input  logic [num_req_p-1:0][addr_width_p-1:0]   req_addr_i,
  input  logic [num_req_p-1:0][data_width_p-1:0]   req_data_i,
  output logic [num_req_p-1:0]                     req_yumi_o,
  output logic                                     net_v_o,
  output logic                                     net_w_o,
  output logic [addr_width_p-1:0]                  net_addr_o,
  output logic [data_width_p-1:0]                  net_data_o,
  input  logic                                     net_ready_i,
  input  logic                                     net_resp_v_i,
  input  logic [data_width_p-1:0]                  net_resp_data_i,
  output logic [num_req_p-1:0]                     resp_v_o,
  output logic [data_width_p-1:0]                  resp_data_o,
  input  logic                                     flush_i,
  output logic                                     flush_done_o,
  output logic                                     err_o,
  output logic [31:0]                              perf_grant_cnt_o,
  output logic [31:0]                              perf_stall_cnt_o
);
  localparam int TW = $clog2(num_req_p);
  localparam int CW = $clog2(max_out_p + 1);

  typedef struct packed {
    logic                    w;
    logic [addr_width_p-1:0] addr;
    logic [data_width_p-1:0] data;
  } out_stage_s;

  sched_state_e            r_state;
  out_stage_s              r_out;
  logic                    r_net_v;
  logic [TW-1:0]           r_last;
  logic [CW-1:0]           r_credit;
  logic [num_req_p-1:0]    r_resp_v;
  logic [data_width_p-1:0] r_resp_data;
  logic                    r_err;

  logic                    w_can_load, w_credit_ok, w_gnt_v, w_rd_gnt, w_pop, w_tag_empty;
  logic [TW-1:0]           w_gnt_idx, w_tag;
  logic [num_req_p-1:0]    w_elig;

  assign w_can_load  = ~r_net_v | net_ready_i;
  assign w_credit_ok = (r_credit < CW'(max_out_p));
  // Writes bypass the credit check; reads need a free credit.
  assign w_elig = (~reset_i && (r_state == SCHED_RUN) && w_can_load)
                ? (req_v_i & (req_w_i | {num_req_p{w_credit_ok}})) : '0;

  // Scan from farthest to nearest so the requester right after r_last wins.
  always_comb begin
    logic [TW-1:0] idx;
    idx       = '0;
    w_gnt_v   = 1'b0;
    w_gnt_idx = '0;
    for (int k = num_req_p; k >= 1; k--) begin
      idx = TW'((int'(r_last) + k) % num_req_p);
      if (w_elig[idx]) begin
        w_gnt_v   = 1'b1;
        w_gnt_idx = idx;
      end
    end
  end

  assign req_yumi_o = w_gnt_v ? (num_req_p'(1) << w_gnt_idx) : '0;
  assign w_rd_gnt   = w_gnt_v & ~req_w_i[w_gnt_idx];
  assign w_pop      = net_resp_v_i & ~w_tag_empty;

  bsg_global_buffer_tag_fifo #(
    .depth_p (max_out_p),
    .width_p (TW)
  ) u_tags (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (w_rd_gnt),
    .data_i  (w_gnt_idx),
    .yumi_i  (w_pop),
    .data_o  (w_tag),
    .empty_o (w_tag_empty)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= SCHED_RUN;
      r_out       <= '0;
      r_net_v     <= 1'b0;
      r_last      <= TW'(num_req_p - 1);
      r_credit    <= '0;
      r_resp_v    <= '0;
      r_resp_data <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_gnt_v) begin
        r_net_v    <= 1'b1;
        r_out.w    <= req_w_i[w_gnt_idx];
        r_out.addr <= req_addr_i[w_gnt_idx];
        r_out.data <= req_data_i[w_gnt_idx];
        r_last     <= w_gnt_idx;
      end else if (net_ready_i) begin
        r_net_v <= 1'b0;
      end

      if (w_rd_gnt & ~w_pop)      r_credit <= r_credit + CW'(1);
      else if (~w_rd_gnt & w_pop) r_credit <= r_credit - CW'(1);

      r_resp_v <= w_pop ? (num_req_p'(1) << w_tag) : '0;
      if (w_pop) r_resp_data <= net_resp_data_i;
      // A response with no tag to pop is dropped and flagged.
      if (net_resp_v_i & w_tag_empty) r_err <= 1'b1;

      unique case (r_state)
        SCHED_RUN:   if (flush_i) r_state <= SCHED_DRAIN;
        SCHED_DRAIN: if (~r_net_v && (r_credit == '0)) r_state <= SCHED_DONE;
        SCHED_DONE:  r_state <= SCHED_RUN;
        default:     r_state <= SCHED_RUN;
      endcase
    end
  end

  assign net_v_o      = r_net_v;
  assign net_w_o      = r_out.w;
  assign net_addr_o   = r_out.addr;
  assign net_data_o   = r_out.data;
  assign resp_v_o     = r_resp_v;
  assign resp_data_o  = r_resp_data;
  assign err_o        = r_err;
  assign flush_done_o = (r_state == SCHED_DONE);

`ifdef BSG_GLOBAL_BUFFER_SCHED_PERF_EN
  logic [31:0] r_grant_cnt, r_stall_cnt;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_grant_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_gnt_v)              r_grant_cnt <= r_grant_cnt + 32'd1;
      if (|req_v_i && !w_gnt_v) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign perf_grant_cnt_o = r_grant_cnt;
  assign perf_stall_cnt_o = r_stall_cnt;
`else
  assign perf_grant_cnt_o = '0;
  assign perf_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bsg_global_buffer_row_sched.sv
// Directed bench for bsg_global_buffer_row_sched with a queue-based reference model.
module tb_bsg_global_buffer_row_sched;
  localparam int NR = 4, AW = 8, DW = 8, MO = 2;

  logic clk = 1'b0, rst;
  logic [NR-1:0] req_v, req_w, yumi, resp_v;
  logic [NR-1:0][AW-1:0] req_addr;
  logic [NR-1:0][DW-1:0] req_data;
  logic net_v, net_w, net_ready, net_resp_v, flush, flush_done, err;
  logic [AW-1:0] net_addr;
  logic [DW-1:0] net_data, net_resp_data, resp_data;
  logic [31:0] perf_g, perf_s;

  int n_checks = 0, n_pass = 0;

  always #5 clk = ~clk;

  bsg_global_buffer_row_sched #(
    .num_req_p(NR), .addr_width_p(AW), .data_width_p(DW), .max_out_p(MO)
  ) dut (
    .clk_i(clk), .reset_i(rst),
    .req_v_i(req_v), .req_w_i(req_w), .req_addr_i(req_addr), .req_data_i(req_data),
    .req_yumi_o(yumi),
    .net_v_o(net_v), .net_w_o(net_w), .net_addr_o(net_addr), .net_data_o(net_data),
    .net_ready_i(net_ready),
    .net_resp_v_i(net_resp_v), .net_resp_data_i(net_resp_data),
    .resp_v_o(resp_v), .resp_data_o(resp_data),
    .flush_i(flush), .flush_done_o(flush_done), .err_o(err),
    .perf_grant_cnt_o(perf_g), .perf_stall_cnt_o(perf_s)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: outstanding reads are simply the tag queue contents.
  int            m_state;  // 0 run, 1 drain, 2 done
  int            m_last;
  int            m_tags[$];
  bit            m_net_v, m_net_w, m_err;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data, m_resp_data;
  logic [NR-1:0] m_resp_v;
  int unsigned   m_gcnt, m_scnt;

  task model_reset();
    m_state = 0; m_last = NR - 1; m_tags.delete();
    m_net_v = 0; m_net_w = 0; m_err = 0; m_addr = '0; m_data = '0;
    m_resp_v = '0; m_resp_data = '0; m_gcnt = 0; m_scnt = 0;
  endtask

  always @(negedge clk) begin
    int pick, nxt, t, i;
    logic [NR-1:0] exp_yumi;
    if (rst) begin
      model_reset();
      check("rst_outputs", {yumi, net_v, resp_v, err, flush_done}, '0);
    end else begin
      check("net_v", net_v, m_net_v);
      if (m_net_v) begin
        check("net_w", net_w, m_net_w);
        check("net_addr", net_addr, m_addr);
        if (m_net_w) check("net_data", net_data, m_data);
      end
      check("resp_v", resp_v, m_resp_v);
      if (m_resp_v != '0) check("resp_data", resp_data, m_resp_data);
      check("err", err, m_err);
      check("flush_done", flush_done, m_state == 2);
`ifdef BSG_GLOBAL_BUFFER_SCHED_PERF_EN
      check("perf_grant", perf_g, m_gcnt);
      check("perf_stall", perf_s, m_scnt);
`else
      check("perf_grant", perf_g, 0);
      check("perf_stall", perf_s, 0);
`endif
      pick = -1;
      for (int k = 1; k <= NR; k++) begin
        i = (m_last + k) % NR;
        if (pick < 0 && req_v[i] && m_state == 0 && (!m_net_v || net_ready) &&
            (req_w[i] || m_tags.size() < MO)) pick = i;
      end
      exp_yumi = (pick >= 0) ? (NR'(1) << pick) : '0;
      check("yumi", yumi, exp_yumi);

      case (m_state)
        0:       nxt = flush ? 1 : 0;
        1:       nxt = (!m_net_v && m_tags.size() == 0) ? 2 : 1;
        default: nxt = 0;
      endcase
      if (|req_v && pick < 0) m_scnt++;
      m_resp_v = '0;
      if (net_resp_v) begin
        if (m_tags.size() > 0) begin
          t = m_tags.pop_front();
          m_resp_v = NR'(1) << t;
          m_resp_data = net_resp_data;
        end else m_err = 1;
      end
      if (pick >= 0) begin
        m_net_v = 1; m_net_w = req_w[pick];
        m_addr = req_addr[pick]; m_data = req_data[pick];
        m_last = pick; m_gcnt++;
        if (!req_w[pick]) m_tags.push_back(pick);
      end else if (net_ready) m_net_v = 0;
      m_state = nxt;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic issue(input int idx, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit got = 0;
    req_v[idx] = 1'b1; req_w[idx] = w; req_addr[idx] = a; req_data[idx] = d;
    for (int c = 0; c < 20 && !got; c++) begin
      sample();
      got = yumi[idx];
      tick();
    end
    req_v[idx] = 1'b0;
    check("issue_granted", got, 1);
  endtask

  task automatic respond(input logic [DW-1:0] d);
    net_resp_v = 1'b1; net_resp_data = d;
    tick();
    net_resp_v = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    rst = 1'b1; req_v = '0; req_w = '0; req_addr = '0; req_data = '0;
    net_ready = 1'b1; net_resp_v = 1'b0; net_resp_data = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sample();
    check("reset_net_v", net_v, 0);
    check("reset_err", err, 0);
    check("reset_resp_v", resp_v, 0);
    tick();

    // Continuous writes from all requesters: strict rotation 0,1,2,3,0.
    req_w = 4'hF;
    for (int i = 0; i < NR; i++) begin
      req_addr[i] = AW'(8'h10 + i);
      req_data[i] = DW'(8'hA0 + i);
    end
    req_v = 4'hF;
    for (int k = 0; k < 5; k++) begin
      sample();
      check("t1_yumi", yumi, 4'b0001 << (k % 4));
      check("t1_net_v", net_v, k > 0);
      if (k == 1) begin
        check("t1_net_addr", net_addr, 8'h10);
        check("t1_net_data", net_data, 8'hA0);
      end
      tick();
    end
    req_v = '0;
    repeat (2) tick();

    // Credit limit: three reads from requester 1, only two fit.
    req_w = '0; req_addr[1] = 8'h21; req_v[1] = 1'b1;
    cnt = 0;
    repeat (6) begin
      sample();
      cnt += int'(yumi[1]);
      tick();
    end
    check("t2_grants_no_resp", cnt, 2);
    net_resp_v = 1'b1; net_resp_data = 8'h55;
    sample();
    check("t2_yumi_resp_cycle", yumi, 4'b0000);
    tick();
    net_resp_v = 1'b0;
    sample();
    check("t2_third_grant", yumi, 4'b0010);
    check("t2_resp_v", resp_v, 4'b0010);
    check("t2_resp_data", resp_data, 8'h55);
    tick();
    req_v = '0;
    respond(8'h56);
    respond(8'h57);
    tick();

    // Credit-blocked reader must not hold up a writer.
    req_addr[2] = 8'h32; req_v[2] = 1'b1;
    repeat (2) tick();
    req_w[3] = 1'b1; req_addr[3] = 8'h43; req_data[3] = 8'hB3; req_v[3] = 1'b1;
    repeat (4) begin
      sample();
      check("t3_writer_only", yumi, 4'b1000);
      tick();
    end
    req_v = '0; req_w = '0;
    respond(8'h61);
    respond(8'h62);
    tick();

    // Response steering follows issue order.
    issue(0, 1'b0, 8'h30, 8'h00);
    issue(3, 1'b0, 8'h33, 8'h00);
    net_resp_v = 1'b1; net_resp_data = 8'h0A;
    tick();
    net_resp_data = 8'h0B;
    sample();
    check("t4_resp_v_a", resp_v, 4'b0001);
    check("t4_resp_data_a", resp_data, 8'h0A);
    tick();
    net_resp_v = 1'b0;
    sample();
    check("t4_resp_v_b", resp_v, 4'b1000);
    check("t4_resp_data_b", resp_data, 8'h0B);
    tick();

    // Flush with two reads outstanding.
    issue(0, 1'b0, 8'h50, 8'h00);
    issue(1, 1'b0, 8'h51, 8'h00);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    req_w[2] = 1'b1; req_addr[2] = 8'h42; req_data[2] = 8'hC2; req_v[2] = 1'b1;
    repeat (3) begin
      sample();
      check("t5_no_grant", yumi, 4'b0000);
      tick();
    end
    respond(8'h71);
    respond(8'h72);
    sample();
    check("t5_done_early", flush_done, 0);
    check("t5_still_blocked", yumi, 4'b0000);
    tick();
    sample();
    check("t5_done_pulse", flush_done, 1);
    tick();
    sample();
    check("t5_done_once", flush_done, 0);
    check("t5_grant_resumes", yumi, 4'b0100);
    tick();
    req_v = '0; req_w = '0;
    tick();

    // Idle flush: pulse two cycles after flush_i.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sample();
    check("t5_idle_done_f1", flush_done, 0);
    tick();
    sample();
    check("t5_idle_done_f2", flush_done, 1);
    tick();

    // Orphan response sets a sticky error.
    respond(8'hEE);
    sample();
    check("t6_err_set", err, 1);
    repeat (3) tick();
    sample();
    check("t6_err_sticky", err, 1);
    tick();

    // Mid-operation reset, then a stale response for a pre-reset read.
    issue(1, 1'b0, 8'h61, 8'h00);
    rst = 1'b1;
    sample();
    check("t6_rst_err", err, 0);
    check("t6_rst_net_v", net_v, 0);
    tick();
    rst = 1'b0;
    respond(8'h99);
    sample();
    check("t6_stale_err", err, 1);
    check("t6_stale_resp_v", resp_v, 4'b0000);
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
